osched_packer: RTL and testbench

//   Write-side counterpart of the 192-bit row scheduler. Collects 48-bit result

---
 rtl/osched_packer.sv | 131 +++++++++++++
 tb/tb_osched_packer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/osched_packer.sv
// osched_packer
//   Write-side packer for the 192-bit row memory. Collects BEAT_W-bit result
//   beats, packs BEATS of them into one word (beat 0 in the most significant
//   slot), and writes each word to sequential addresses starting at BASE_ADDR.
//   A beat with in_last closes the word early; unfilled slots are zero.
//
//   Build option: OSCHED_ADDR_WRAP_EN
//     defined     - after the write at the top address, mem_addr wraps to
//                   BASE_ADDR and full stays 0.
//     not defined - after that write, full is set, mem_addr holds the top
//                   address and no beat is accepted until start or reset.
//
//   Ports
//     clock, reset      rising-edge clock, synchronous active-high reset
//     start             1-cycle restart: address back to BASE_ADDR, partial
//                       word and any pending write are dropped
//     in_valid/in_ready beat handshake (in_data, in_last)
//     mem_we/mem_ready  write handshake (mem_addr, mem_wdata)
//     full              address space exhausted (non-wrap build)
//     dbgState          FSM state, 0 = FILL, 1 = WRITE
//
//   Handshake rule (both interfaces): a transfer happens on a rising edge
//   where valid and ready are both high; the producer holds valid and its
//   payload stable until that edge. mem_ready while mem_we is low is ignored.
module osched_packer #(
  parameter int BEAT_W    = 48,
  parameter int BEATS     = 4,
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      in_valid,
  input  logic [BEAT_W-1:0]         in_data,
  input  logic                      in_last,
  output logic                      in_ready,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [BEAT_W*BEATS-1:0]   mem_wdata,
  input  logic                      mem_ready,
  output logic                      full,
  output logic                      dbgState
);

  localparam int WORD_W = BEAT_W * BEATS;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] MAX_ADDR = '1;
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic {
    FILL  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t              state;
  state_t              stateNext;
  logic [CNT_W-1:0]    beatCnt;
  logic [WORD_W-1:0]   asmReg;
  logic [WORD_W-1:0]   asmNext;
  logic                accept;
  logic                closeWord;
  logic                writeDone;

  assign in_ready  = (state == FILL) && !full && !start && !reset;
  assign accept    = in_valid && in_ready;
  assign closeWord = accept && (in_last || (beatCnt == LAST_BEAT));
  assign writeDone = (state == WRITE) && mem_ready;
  assign dbgState  = state;

  // Assembly word with the incoming beat dropped into slot beatCnt.
  always_comb begin
    asmNext = asmReg;
    for (int k = 0; k < BEATS; k++) begin
      if (beatCnt == CNT_W'(k)) begin
        asmNext[WORD_W-1-BEAT_W*k -: BEAT_W] = in_data;
      end
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      FILL:    if (closeWord) stateNext = WRITE;
      WRITE:   if (mem_ready) stateNext = FILL;
      default: stateNext = FILL;
    endcase
    if (start) stateNext = FILL;
  end

  always_ff @(posedge clock) begin
    if (reset) state <= FILL;
    else       state <= stateNext;
  end

  always_ff @(posedge clock) begin
    if (reset || start) begin
      beatCnt  <= '0;
      asmReg   <= '0;
      mem_we   <= 1'b0;
      mem_addr <= BASE;
      full     <= 1'b0;
      // start leaves the last written word on mem_wdata; only reset clears it.
      if (reset) mem_wdata <= '0;
    end else begin
      if (closeWord) begin
        mem_wdata <= asmNext;
        asmReg    <= '0;
        beatCnt   <= '0;
        mem_we    <= 1'b1;
      end else if (accept) begin
        asmReg  <= asmNext;
        beatCnt <= beatCnt + 1'b1;
      end
      if (writeDone) begin
        mem_we <= 1'b0;
        if (mem_addr == MAX_ADDR) begin
`ifdef OSCHED_ADDR_WRAP_EN
          mem_addr <= BASE;
`else
          full <= 1'b1;
`endif
        end else begin
          mem_addr <= mem_addr + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_osched_packer.sv
module tb_osched_packer;

  localparam int BW = 48;
  localparam int NB = 4;
  localparam int WW = BW * NB;
  localparam int AW = 2;

  localparam logic [BW-1:0] BA = 48'hA0A0_0000_0001;
  localparam logic [BW-1:0] BB = 48'hB0B0_0000_0002;
  localparam logic [BW-1:0] BC = 48'hC0C0_0000_0003;
  localparam logic [BW-1:0] BD = 48'hD0D0_0000_0004;
  localparam logic [BW-1:0] BE = 48'hE0E0_0000_0005;
  localparam logic [BW-1:0] BF = 48'hF0F0_0000_0006;
  localparam logic [BW-1:0] BG = 48'h1212_0000_0007;
  localparam logic [BW-1:0] BX = 48'h3434_0000_0008;
  localparam logic [BW-1:0] BY = 48'h5656_0000_0009;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [BW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [WW-1:0] mem_wdata;
  logic          mem_ready = 1'b1;
  logic          full;
  logic          dbgState;

  int total = 0;
  int bad   = 0;

  logic [AW+WW-1:0] exp_q[$];

  // Reference model of the packing and address sequence.
  logic [WW-1:0] mAsm;
  int            mCnt;
  int            mAddr;
  bit            mFull;

  osched_packer #(.BEAT_W(BW), .BEATS(NB), .ADDR_W(AW), .BASE_ADDR(0)) dut (
    .clock(clock), .reset(reset), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .full(full), .dbgState(dbgState)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted memory write is checked against the queue.
  always @(negedge clock) begin
    if (!reset && mem_we && mem_ready && !start) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected_write: got addr %0d data %h expected nothing", mem_addr, mem_wdata);
      end else begin
        logic [AW+WW-1:0] e;
        e = exp_q.pop_front();
        chk("sb_addr", WW'(mem_addr), WW'(e[AW+WW-1:WW]));
        chk("sb_data", mem_wdata, e[WW-1:0]);
      end
    end
  end

  function automatic void modelStart();
    mAsm  = '0;
    mCnt  = 0;
    mAddr = 0;
    mFull = 0;
  endfunction

  function automatic void modelAccept(input logic [BW-1:0] d, input logic lst);
    mAsm[WW-1-BW*mCnt -: BW] = d;
    mCnt++;
    if (lst || mCnt == NB) begin
      exp_q.push_back({AW'(mAddr), mAsm});
      mAsm = '0;
      mCnt = 0;
      if (mAddr == (1 << AW) - 1) begin
`ifdef OSCHED_ADDR_WRAP_EN
        mAddr = 0;
`else
        mFull = 1;
`endif
      end else begin
        mAddr++;
      end
    end
  endfunction

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic sendBeat(input logic [BW-1:0] d, input logic lst);
    int  n = 0;
    bit  done = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = lst;
    while (!done && n < 50) begin
      @(negedge clock);
      if (in_ready) begin
        modelAccept(d, lst);
        done = 1;
      end
      @(posedge clock);
      #1;
      n++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got no in_ready in 50 cycles expected acceptance");
    end
  endtask

  task automatic doStart();
    idle(2);
    start = 1'b1;
    @(negedge clock);
    chk("start_blocks_ready", WW'(in_ready), '0);
    @(posedge clock);
    #1;
    start = 1'b0;
    modelStart();
    @(negedge clock);
    chk("start_addr", WW'(mem_addr), '0);
    chk("start_we", WW'(mem_we), '0);
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic          st;
    logic          iv;
    logic [BW-1:0] d;
    logic          lst;
    logic          mr;
    logic          eIr;
    logic          eWe;
    logic [AW-1:0] eAddr;
    logic          chkData;
    logic [WW-1:0] eData;
  } vec_t;

  function automatic vec_t mkv(input logic st, input logic iv, input logic [BW-1:0] d,
                               input logic lst, input logic mr, input logic eIr,
                               input logic eWe, input logic [AW-1:0] eAddr,
                               input logic chkData, input logic [WW-1:0] eData);
    vec_t v;
    v.st = st; v.iv = iv; v.d = d; v.lst = lst; v.mr = mr;
    v.eIr = eIr; v.eWe = eWe; v.eAddr = eAddr; v.chkData = chkData; v.eData = eData;
    return v;
  endfunction

  vec_t vecs[17];

  initial begin
    logic [WW-1:0] wABCD;
    logic [WW-1:0] wE;
    logic [WW-1:0] wXY;
    logic [63:0]   r;
    wABCD = {BA, BB, BC, BD};
    wE    = {BE, 144'b0};
    wXY   = {BX, BY, 96'b0};

    // Cycle table: full word, 3-cycle write stall, single-beat row end,
    // start mid-word, start during a stalled write.
    vecs[0]  = mkv(0, 1, BA, 0, 1,  1, 0, 2'd0, 0, '0);
    vecs[1]  = mkv(0, 1, BB, 0, 1,  1, 0, 2'd0, 0, '0);
    vecs[2]  = mkv(0, 1, BC, 0, 1,  1, 0, 2'd0, 0, '0);
    vecs[3]  = mkv(0, 1, BD, 0, 1,  1, 0, 2'd0, 0, '0);
    vecs[4]  = mkv(0, 0, '0, 0, 0,  0, 1, 2'd0, 1, wABCD);
    vecs[5]  = mkv(0, 0, '0, 0, 0,  0, 1, 2'd0, 1, wABCD);
    vecs[6]  = mkv(0, 0, '0, 0, 0,  0, 1, 2'd0, 1, wABCD);
    vecs[7]  = mkv(0, 0, '0, 0, 1,  0, 1, 2'd0, 1, wABCD);
    vecs[8]  = mkv(0, 1, BE, 1, 1,  1, 0, 2'd1, 0, '0);
    vecs[9]  = mkv(0, 0, '0, 0, 1,  0, 1, 2'd1, 1, wE);
    vecs[10] = mkv(0, 1, BF, 0, 1,  1, 0, 2'd2, 0, '0);
    vecs[11] = mkv(1, 1, BG, 0, 1,  0, 0, 2'd2, 0, '0);
    vecs[12] = mkv(0, 1, BX, 0, 1,  1, 0, 2'd0, 0, '0);
    vecs[13] = mkv(0, 1, BY, 1, 1,  1, 0, 2'd0, 0, '0);
    vecs[14] = mkv(0, 0, '0, 0, 0,  0, 1, 2'd0, 1, wXY);
    vecs[15] = mkv(1, 0, '0, 0, 0,  0, 1, 2'd0, 1, wXY);
    vecs[16] = mkv(0, 0, '0, 0, 1,  1, 0, 2'd0, 0, '0);
    modelStart();

    // Reset state.
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_in_ready", WW'(in_ready), '0);
    chk("rst_we", WW'(mem_we), '0);
    chk("rst_addr", WW'(mem_addr), '0);
    chk("rst_wdata", mem_wdata, '0);
    chk("rst_full", WW'(full), '0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Table run; the two completed writes go through the scoreboard.
    exp_q.push_back({2'd0, wABCD});
    exp_q.push_back({2'd1, wE});
    for (int i = 0; i < 17; i++) begin
      start     = vecs[i].st;
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].d;
      in_last   = vecs[i].lst;
      mem_ready = vecs[i].mr;
      @(negedge clock);
      chk($sformatf("v%0d_ready", i), WW'(in_ready), WW'(vecs[i].eIr));
      chk($sformatf("v%0d_we", i), WW'(mem_we), WW'(vecs[i].eWe));
      chk($sformatf("v%0d_addr", i), WW'(mem_addr), WW'(vecs[i].eAddr));
      if (vecs[i].chkData) chk($sformatf("v%0d_wdata", i), mem_wdata, vecs[i].eData);
      @(posedge clock);
      #1;
    end
    start     = 1'b0;
    mem_ready = 1'b1;
    chk("table_writes_seen", WW'(exp_q.size()), '0);

    // Back-to-back full words, then early row ends.
    doStart();
    sendBeat(BA, 0); sendBeat(BB, 0); sendBeat(BC, 0); sendBeat(BD, 0);
    sendBeat(BE, 0); sendBeat(BF, 0); sendBeat(BG, 0); sendBeat(BX, 0);
    idle(3);
    doStart();
    sendBeat(BA, 0); sendBeat(BB, 1);
    sendBeat(BE, 1);
    idle(3);

    // Address space end.
    doStart();
    for (int w = 0; w < 4; w++)
      for (int b = 0; b < NB; b++) begin
        r = {$urandom(), $urandom()};
        sendBeat(r[BW-1:0], 1'b0);
      end
    idle(3);
    @(negedge clock);
`ifdef OSCHED_ADDR_WRAP_EN
    chk("end_full", WW'(full), '0);
    chk("end_addr", WW'(mem_addr), '0);
    chk("end_in_ready", WW'(in_ready), WW'(1'b1));
    @(posedge clock);
    #1;
    for (int b = 0; b < NB; b++) sendBeat(BA + BW'(b), 1'b0);
    idle(3);
`else
    chk("end_full", WW'(full), WW'(1'b1));
    chk("end_addr", WW'(mem_addr), WW'(2'd3));
    chk("end_in_ready", WW'(in_ready), '0);
    @(posedge clock);
    #1;
`endif

    // Continuous valid with random row ends.
    doStart();
    for (int i = 0; i < 40; i++) begin
      if (mFull) doStart();
      r = {$urandom(), $urandom()};
      sendBeat(r[BW-1:0], (i == 39) || ($urandom_range(0, 3) == 0));
    end
    idle(4);

    chk("queue_empty", WW'(exp_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
